// File: rtl/ac_motor_dead_time_n.sv
// N-leg dead-time generator: complementary gate drives, abortable dead interval, safe start, sticky fault.
// Optional minimum on-time hold is compiled in with AC_MOTOR_DEAD_TIME_MIN_ON_EN.
module ac_motor_dead_time_n #(
    parameter int CHANNELS = 3,
    parameter int DELAY_W  = 8,
    parameter int MIN_ON   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [DELAY_W-1:0]  delay,
    input  logic [CHANNELS-1:0] s,
    output logic [CHANNELS-1:0] high,
    output logic [CHANNELS-1:0] low,
    output logic                fault
);

    localparam logic [2:0] S_OFF = 3'd0;
    localparam logic [2:0] S_HIGH_ON = 3'd1;
    localparam logic [2:0] S_DEAD_TO_LOW = 3'd2;
    localparam logic [2:0] S_LOW_ON = 3'd3;
    localparam logic [2:0] S_DEAD_TO_HIGH = 3'd4;

    logic [2:0]          r_state    [CHANNELS];
    logic [DELAY_W-1:0]  r_cnt      [CHANNELS];
    logic [CHANNELS-1:0] r_from_off;
    logic [CHANNELS-1:0] r_high;
    logic [CHANNELS-1:0] r_low;
    logic                r_fault;

    logic [2:0]          w_nstate   [CHANNELS];
    logic [DELAY_W-1:0]  w_ncnt     [CHANNELS];
    logic [CHANNELS-1:0] w_nfrom_off;
    logic [CHANNELS-1:0] w_nhigh;
    logic [CHANNELS-1:0] w_nlow;
    logic [CHANNELS-1:0] w_hold_ok;
    logic [DELAY_W-1:0]  w_dead;
    logic                w_fault_now;
    logic                w_force_off;

`ifdef AC_MOTOR_DEAD_TIME_MIN_ON_EN
    localparam int HOLD_W = (MIN_ON > 1) ? $clog2(MIN_ON) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'((MIN_ON > 1) ? MIN_ON - 1 : 0);
    logic [HOLD_W-1:0] r_hold  [CHANNELS];
    logic [HOLD_W-1:0] w_nhold [CHANNELS];
`endif

    assign w_dead      = (delay == '0) ? DELAY_W'(1) : delay;
    assign w_fault_now = |(r_high & r_low);
    assign w_force_off = !enable || r_fault || w_fault_now;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_nstate[i]    = r_state[i];
            w_ncnt[i]      = r_cnt[i];
            w_nfrom_off[i] = r_from_off[i];
`ifdef AC_MOTOR_DEAD_TIME_MIN_ON_EN
            w_nhold[i]     = r_hold[i];
            w_hold_ok[i]   = (r_hold[i] == '0);
`else
            w_hold_ok[i]   = 1'b1;
`endif
            case (r_state[i])
                S_OFF: if (enable) begin
                    w_nstate[i]    = s[i] ? S_DEAD_TO_HIGH : S_DEAD_TO_LOW;
                    w_ncnt[i]      = w_dead;
                    w_nfrom_off[i] = 1'b1;
                end
                S_HIGH_ON: if (!s[i] && w_hold_ok[i]) begin
                    w_nstate[i]    = S_DEAD_TO_LOW;
                    w_ncnt[i]      = w_dead;
                    w_nfrom_off[i] = 1'b0;
                end
                S_LOW_ON: if (s[i] && w_hold_ok[i]) begin
                    w_nstate[i]    = S_DEAD_TO_HIGH;
                    w_ncnt[i]      = w_dead;
                    w_nfrom_off[i] = 1'b0;
                end
                // A reversal after safe start restarts the count: the other switch may have been off for an unknown time.
                S_DEAD_TO_LOW: begin
                    if (s[i]) begin
                        w_nstate[i] = r_from_off[i] ? S_DEAD_TO_HIGH : S_HIGH_ON;
                        w_ncnt[i]   = w_dead;
                    end else if (r_cnt[i] <= DELAY_W'(1)) begin
                        w_nstate[i] = S_LOW_ON;
                    end else begin
                        w_ncnt[i]   = r_cnt[i] - DELAY_W'(1);
                    end
                end
                S_DEAD_TO_HIGH: begin
                    if (!s[i]) begin
                        w_nstate[i] = r_from_off[i] ? S_DEAD_TO_LOW : S_LOW_ON;
                        w_ncnt[i]   = w_dead;
                    end else if (r_cnt[i] <= DELAY_W'(1)) begin
                        w_nstate[i] = S_HIGH_ON;
                    end else begin
                        w_ncnt[i]   = r_cnt[i] - DELAY_W'(1);
                    end
                end
                default: w_nstate[i] = S_OFF;
            endcase
`ifdef AC_MOTOR_DEAD_TIME_MIN_ON_EN
            if ((w_nstate[i] == S_HIGH_ON || w_nstate[i] == S_LOW_ON) && w_nstate[i] != r_state[i])
                w_nhold[i] = HOLD_INIT;
            else if (r_hold[i] != '0)
                w_nhold[i] = r_hold[i] - HOLD_W'(1);
`endif
            if (w_force_off) begin
                w_nstate[i]    = S_OFF;
                w_ncnt[i]      = '0;
                w_nfrom_off[i] = 1'b0;
`ifdef AC_MOTOR_DEAD_TIME_MIN_ON_EN
                w_nhold[i]     = '0;
`endif
            end
            w_nhigh[i] = (w_nstate[i] == S_HIGH_ON);
            w_nlow[i]  = (w_nstate[i] == S_LOW_ON);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= S_OFF;
                r_cnt[i]   <= '0;
`ifdef AC_MOTOR_DEAD_TIME_MIN_ON_EN
                r_hold[i]  <= '0;
`endif
            end
            r_from_off <= '0;
            r_high     <= '0;
            r_low      <= '0;
            r_fault    <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= w_nstate[i];
                r_cnt[i]   <= w_ncnt[i];
`ifdef AC_MOTOR_DEAD_TIME_MIN_ON_EN
                r_hold[i]  <= w_nhold[i];
`endif
            end
            r_from_off <= w_nfrom_off;
            r_high     <= w_nhigh;
            r_low      <= w_nlow;
            r_fault    <= r_fault | w_fault_now;
        end
    end

    assign high  = r_high;
    assign low   = r_low;
    assign fault = r_fault;

endmodule

// File: tb/tb_ac_motor_dead_time_n.sv
// Directed and random checks of ac_motor_dead_time_n with a queue of expected {high,low,fault} per edge.
module tb_ac_motor_dead_time_n;

    localparam int CH = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [7:0]    delay = '0;
    logic [CH-1:0] s = '0;
    logic [CH-1:0] high;
    logic [CH-1:0] low;
    logic          fault;

    int errors = 0;
    int checks = 0;
    logic [2*CH:0] q_exp[$];
    string         q_tag[$];

    ac_motor_dead_time_n #(.CHANNELS(CH), .DELAY_W(8), .MIN_ON(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .delay(delay),
        .s(s), .high(high), .low(low), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check_out();
        logic [2*CH:0] exp_v;
        string         tag;
        logic [2*CH:0] obs;
        exp_v = q_exp.pop_front();
        tag   = q_tag.pop_front();
        obs   = {high, low, fault};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed high/low/fault=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic cyc(input logic en, input logic [CH-1:0] sv, input logic [7:0] dl,
                       input logic [CH-1:0] eh, input logic [CH-1:0] el, input string tag);
        enable = en;
        s      = sv;
        delay  = dl;
        q_exp.push_back({eh, el, 1'b0});
        q_tag.push_back(tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic all(input logic en, input logic b, input logic [7:0] dl,
                       input logic h, input logic l, input int n, input string tag);
        for (int k = 0; k < n; k++)
            cyc(en, {CH{b}}, dl, {CH{h}}, {CH{l}}, tag);
    endtask

    initial begin
        logic [1:0]    st [CH];
        logic [CH-1:0] sv, eh, el;

        @(posedge clk);
        #1;
        all(0, 1, 5, 0, 0, 2, "reset");
        rst_n = 1'b1;

        all(1, 1, 5, 0, 0, 5, "safe_start");
        all(1, 1, 5, 1, 0, 5, "start_high");
        all(1, 0, 8, 0, 0, 8, "dead8");
        all(1, 0, 8, 0, 1, 5, "low_on");
        all(1, 1, 3, 0, 0, 3, "dead3");
        all(1, 1, 3, 1, 0, 5, "high_on");
        all(1, 0, 10, 0, 0, 3, "abort_dead");
        all(1, 1, 10, 1, 0, 5, "abort_high");

        all(0, 1, 4, 0, 0, 1, "en_off");
        all(1, 1, 4, 0, 0, 1, "reen");
        all(1, 0, 4, 0, 0, 4, "restart");
        all(1, 0, 4, 0, 1, 5, "restart_low");

        all(0, 0, 2, 0, 0, 1, "drop_on");
        all(1, 0, 2, 0, 0, 1, "reen2");
        all(0, 0, 2, 0, 0, 1, "drop_dead");
        all(1, 0, 2, 0, 0, 2, "reen3");
        all(1, 0, 2, 0, 1, 5, "reen3_low");

        all(1, 1, 2, 0, 0, 1, "dly_entry");
        all(1, 1, 9, 0, 0, 1, "dly_mid");
        all(1, 1, 9, 1, 0, 5, "dly_kept");

        all(1, 0, 6, 0, 0, 2, "pre_rst");
        rst_n = 1'b0;
        all(1, 0, 6, 0, 0, 1, "rst_mid");
        rst_n = 1'b1;
        all(1, 0, 6, 0, 0, 6, "post_rst");
        all(1, 0, 6, 0, 1, 5, "post_rst_low");

        all(1, 1, 2, 0, 0, 2, "pulse1");
        all(1, 0, 2, 0, 1, 1, "pulse1_abort");
`ifdef AC_MOTOR_DEAD_TIME_MIN_ON_EN
        all(1, 1, 2, 0, 1, 2, "pulse2_hold");
`else
        all(1, 1, 2, 0, 0, 2, "pulse2");
`endif
        all(1, 0, 2, 0, 1, 4, "pulse2_end");

`ifndef AC_MOTOR_DEAD_TIME_MIN_ON_EN
        // Every leg starts in LOW_ON; with delay=0 a dead interval is one cycle and then follows s.
        for (int c = 0; c < CH; c++) st[c] = 2'd2;
        for (int n = 0; n < 400; n++) begin
            sv = CH'($urandom);
            for (int c = 0; c < CH; c++) begin
                if (st[c] == 2'd0)
                    st[c] = sv[c] ? 2'd1 : 2'd2;
                else if ((st[c] == 2'd1) != sv[c])
                    st[c] = 2'd0;
                eh[c] = (st[c] == 2'd1);
                el[c] = (st[c] == 2'd2);
            end
            cyc(1, sv, 0, eh, el, "rand_d0");
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
